// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button front end.
package btn_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } arb_state_t;

  // Defaults sized for a 100 MHz clock: 1 ms sample period, 20 ms settle time.
  localparam int DEF_TICK_DIV     = 100000;
  localparam int DEF_STABLE_TICKS = 20;

endpackage

// File: rtl/button_event_ctrl_if.sv
// Valid/ready event port carrying the index of a newly pressed button.
interface button_event_ctrl_if #(
  parameter int IDX_W = 2
);

  logic             evt_valid;
  logic [IDX_W-1:0] evt_idx;
  logic             evt_ready;

  modport master (
    output evt_valid,
    output evt_idx,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_idx,
    output evt_ready
  );

endinterface

// File: rtl/debounce_slot.sv
// One debounce channel: accepts a new level after STABLE_TICKS consecutive
// disagreeing samples, and flags the accepting edge of a 0->1 change.
module debounce_slot
  import btn_pkg::*;
#(
  parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_s,
  output logic level,
  output logic rise
);

  localparam int STAB_W = $clog2(STABLE_TICKS + 1);

  logic [STAB_W-1:0] stab;
  logic              accept;

  // Decoded combinationally so the press is visible on the same edge the level flips.
  assign accept = tick && (btn_s != level) && (stab == STAB_W'(STABLE_TICKS - 1));
  assign rise   = accept && !level;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level <= 1'b0;
      stab  <= '0;
    end else if (tick) begin
      if (btn_s == level) begin
        stab <= '0;
      end else if (accept) begin
        level <= ~level;
        stab  <= '0;
      end else begin
        stab <= stab + STAB_W'(1);
      end
    end
  end

endmodule

// File: rtl/button_event_ctrl.sv
// Push-button front end: synchronise, debounce, queue presses and hand them
// to the CPU I/O logic one at a time through a round-robin arbiter.
module button_event_ctrl
  import btn_pkg::*;
#(
  parameter int N_BTN        = 4,
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int STABLE_TICKS = DEF_STABLE_TICKS,
  parameter int IDX_W        = $clog2(N_BTN)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_BTN-1:0]     btn_raw,
  output logic [N_BTN-1:0]     level,
  output logic                 overrun,
  input  logic                 overrun_clr,
  button_event_ctrl_if.master  evt
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(N_BTN - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  logic [N_BTN-1:0] btn_meta;
  logic [N_BTN-1:0] btn_s;
  logic [CNT_W-1:0] presc;
  logic             tick;
  logic [N_BTN-1:0] rise;
  logic [N_BTN-1:0] pending;
  logic [N_BTN-1:0] clr_mask;
  logic             lost;
  arb_state_t       state;
  logic [IDX_W-1:0] ptr;
  logic             grant_found;
  logic [IDX_W-1:0] grant_idx;
  logic [IDX_W-1:0] cand;
  logic             grant_fire;
  logic             evt_valid_q;
  logic [IDX_W-1:0] evt_idx_q;

  assign evt.evt_valid = evt_valid_q;
  assign evt.evt_idx   = evt_idx_q;

  // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_meta <= '0;
      btn_s    <= '0;
    end else begin
      btn_meta <= btn_raw;
      btn_s    <= btn_meta;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + CNT_W'(1);
    end
  end

  assign tick = (presc == CNT_W'(TICK_DIV - 1));

  for (genvar i = 0; i < N_BTN; i++) begin : g_slot
    debounce_slot #(
      .STABLE_TICKS(STABLE_TICKS)
    ) u_slot (
      .clk   (clk),
      .rst   (rst),
      .tick  (tick),
      .btn_s (btn_s[i]),
      .level (level[i]),
      .rise  (rise[i])
    );
  end

  // Round-robin search starts just above the last granted index.
  // NOTE: every always_comb output gets a default first, so no latch is inferred.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = next_idx(ptr);
    for (int k = 0; k < N_BTN; k++) begin
      if (!grant_found && pending[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
      cand = next_idx(cand);
    end
  end

  assign grant_fire = (state == IDLE) && grant_found;
  assign clr_mask   = grant_fire ? (N_BTN'(1) << grant_idx) : '0;
  // A press arriving on its own grant edge re-arms the bit and is not a loss.
  assign lost       = |(rise & pending & ~clr_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      pending <= (pending & ~clr_mask) | rise;
      if (lost) begin
        overrun <= 1'b1;
      end else if (overrun_clr) begin
        overrun <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      ptr         <= IDX_W'(N_BTN - 1);
      evt_valid_q <= 1'b0;
      evt_idx_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_found) begin
            evt_valid_q <= 1'b1;
            evt_idx_q   <= grant_idx;
            ptr         <= grant_idx;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (evt_valid_q && evt.evt_ready) begin
            evt_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_button_event_ctrl.sv
// Directed bench for button_event_ctrl with a short tick so debounce timing is exact.
module tb_button_event_ctrl;

  localparam int N_BTN        = 4;
  localparam int TICK_DIV     = 4;
  localparam int STABLE_TICKS = 3;
  localparam int IDX_W        = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] level;
  logic             overrun;
  logic             overrun_clr;

  button_event_ctrl_if #(.IDX_W(IDX_W)) evt_if ();

  button_event_ctrl #(
    .N_BTN        (N_BTN),
    .TICK_DIV     (TICK_DIV),
    .STABLE_TICKS (STABLE_TICKS),
    .IDX_W        (IDX_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_raw     (btn_raw),
    .level       (level),
    .overrun     (overrun),
    .overrun_clr (overrun_clr),
    .evt         (evt_if)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int edge_count = 0;
  int valid_cycles = 0;
  int level_cycles = 0;
  logic [IDX_W-1:0] hs_log[$];

  // Edges since reset release: sample ticks fall on every 4th edge.
  always @(posedge clk) begin
    if (rst) edge_count <= 0;
    else     edge_count <= edge_count + 1;
    if (!rst && evt_if.evt_valid) valid_cycles <= valid_cycles + 1;
    if (!rst && (level != '0))    level_cycles <= level_cycles + 1;
    if (!rst && evt_if.evt_valid && evt_if.evt_ready) hs_log.push_back(evt_if.evt_idx);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic wait_level(input int b, input logic v, input int budget, input string tag,
                            output int n);
    n = 0;
    while (level[b] !== v && n < budget) begin
      step();
      n++;
    end
    check(tag, level[b], v);
  endtask

  task automatic wait_valid(input int budget, input string tag);
    int n = 0;
    while (evt_if.evt_valid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
    check(tag, evt_if.evt_valid, 1'b1);
  endtask

  function automatic logic [31:0] hs_at(input int i);
    return (i < hs_log.size()) ? 32'(hs_log[i]) : 32'hdead;
  endfunction

  function automatic int ceil4(input int x);
    return ((x + 3) / 4) * 4;
  endfunction

  initial begin
    int n, base_v, base_l, base_h, k, r;

    rst = 1'b1;
    btn_raw = '0;
    overrun_clr = 1'b0;
    evt_if.evt_ready = 1'b0;
    step();
    step();
    check("rst_level", level, 4'b0000);
    check("rst_valid", evt_if.evt_valid, 1'b0);
    check("rst_idx", evt_if.evt_idx, 2'd0);
    check("rst_overrun", overrun, 1'b0);
    rst = 1'b0;

    // Glitch: 6 cycles high covers at most 2 sample ticks.
    base_v = valid_cycles;
    base_l = level_cycles;
    btn_raw = 4'b0010;
    repeat (6) step();
    btn_raw = 4'b0000;
    repeat (30) step();
    check("glitch_valid", valid_cycles - base_v, 0);
    check("glitch_level", level_cycles - base_l, 0);
    check("glitch_overrun", overrun, 1'b0);

    // Clean press with the consumer always ready.
    evt_if.evt_ready = 1'b1;
    base_h = hs_log.size();
    btn_raw = 4'b0100;
    wait_level(2, 1'b1, 20, "press_level", n);
    check("press_latency_le15", n <= 15, 1'b1);
    check("press_valid_same", evt_if.evt_valid, 1'b0);
    step();
    check("press_valid", evt_if.evt_valid, 1'b1);
    check("press_idx", evt_if.evt_idx, 2'd2);
    step();
    check("press_valid_1cyc", evt_if.evt_valid, 1'b0);
    repeat (40 - n - 2) step();
    btn_raw = 4'b0000;
    wait_level(2, 1'b0, 20, "release_level", n);
    repeat (20) step();
    check("release_no_evt", hs_log.size() - base_h, 1);
    check("press_hs_idx", hs_at(base_h), 2);

    // Arbitration: btn0 and btn3 together, consumer stalls 10 cycles.
    evt_if.evt_ready = 1'b0;
    do_reset();
    btn_raw = 4'b1001;
    wait_valid(20, "arb_valid");
    for (int i = 0; i < 10; i++) begin
      check("arb_hold_valid", evt_if.evt_valid, 1'b1);
      check("arb_hold_idx", evt_if.evt_idx, 2'd0);
      step();
    end
    evt_if.evt_ready = 1'b1;
    step();
    check("arb_idle_gap", evt_if.evt_valid, 1'b0);
    step();
    check("arb_second_valid", evt_if.evt_valid, 1'b1);
    check("arb_second_idx", evt_if.evt_idx, 2'd3);
    step();
    check("arb_second_done", evt_if.evt_valid, 1'b0);
    btn_raw = 4'b0000;
    wait_level(0, 1'b0, 20, "arb_rel0", n);
    wait_level(3, 1'b0, 20, "arb_rel3", n);
    base_h = hs_log.size();
    btn_raw = 4'b1001;
    repeat (30) step();
    check("arb_rr_count", hs_log.size() - base_h, 2);
    check("arb_rr_first", hs_at(base_h), 0);
    check("arb_rr_second", hs_at(base_h + 1), 3);
    btn_raw = 4'b0000;
    wait_level(0, 1'b0, 20, "arb_rr_rel0", n);
    wait_level(3, 1'b0, 20, "arb_rr_rel3", n);

    // Overrun: second press of btn2 while its first press is still queued.
    evt_if.evt_ready = 1'b0;
    do_reset();
    btn_raw = 4'b0010;
    wait_valid(20, "ovr_valid");
    check("ovr_idx", evt_if.evt_idx, 2'd1);
    btn_raw = 4'b0110;
    wait_level(2, 1'b1, 20, "ovr_press1", n);
    check("ovr_not_yet", overrun, 1'b0);
    btn_raw = 4'b0010;
    wait_level(2, 1'b0, 20, "ovr_release", n);
    btn_raw = 4'b0110;
    wait_level(2, 1'b1, 20, "ovr_press2", n);
    check("ovr_set", overrun, 1'b1);
    check("ovr_hold_idx", evt_if.evt_idx, 2'd1);
    overrun_clr = 1'b1;
    step();
    overrun_clr = 1'b0;
    check("ovr_clear", overrun, 1'b0);
    base_h = hs_log.size();
    evt_if.evt_ready = 1'b1;
    repeat (10) step();
    check("ovr_drain_count", hs_log.size() - base_h, 2);
    check("ovr_drain_first", hs_at(base_h), 1);
    check("ovr_drain_second", hs_at(base_h + 1), 2);
    btn_raw = 4'b0000;
    wait_level(1, 1'b0, 20, "ovr_rel1", n);
    wait_level(2, 1'b0, 20, "ovr_rel2", n);

    // Collision: btn2 re-press accepted on the very edge its pending bit is granted.
    evt_if.evt_ready = 1'b0;
    do_reset();
    btn_raw = 4'b0110;
    wait_valid(20, "col_valid");
    check("col_idx", evt_if.evt_idx, 2'd1);
    btn_raw = 4'b0010;
    wait_level(2, 1'b0, 20, "col_release", n);
    base_h = hs_log.size();
    k = edge_count;
    btn_raw = 4'b0110;
    r = ceil4(k + 3) + 8;
    while (edge_count < r - 2) step();
    evt_if.evt_ready = 1'b1;
    step();
    check("col_hs_gap", evt_if.evt_valid, 1'b0);
    check("col_level_pre", level[2], 1'b0);
    step();
    check("col_level_rise", level[2], 1'b1);
    check("col_grant_valid", evt_if.evt_valid, 1'b1);
    check("col_grant_idx", evt_if.evt_idx, 2'd2);
    check("col_no_overrun", overrun, 1'b0);
    step();
    check("col_gap2", evt_if.evt_valid, 1'b0);
    step();
    check("col_again_valid", evt_if.evt_valid, 1'b1);
    check("col_again_idx", evt_if.evt_idx, 2'd2);
    repeat (10) step();
    check("col_count", hs_log.size() - base_h, 3);
    check("col_seq0", hs_at(base_h), 1);
    check("col_seq1", hs_at(base_h + 1), 2);
    check("col_seq2", hs_at(base_h + 2), 2);
    check("col_overrun_end", overrun, 1'b0);
    btn_raw = 4'b0000;
    wait_level(1, 1'b0, 20, "col_rel1", n);
    wait_level(2, 1'b0, 20, "col_rel2", n);

    // Reset mid-event with btn0 held throughout.
    evt_if.evt_ready = 1'b0;
    do_reset();
    btn_raw = 4'b0001;
    wait_valid(20, "rme_valid");
    check("rme_idx", evt_if.evt_idx, 2'd0);
    rst = 1'b1;
    #1;
    check("rme_level", level, 4'b0000);
    check("rme_valid0", evt_if.evt_valid, 1'b0);
    check("rme_idx0", evt_if.evt_idx, 2'd0);
    check("rme_overrun", overrun, 1'b0);
    step();
    step();
    rst = 1'b0;
    base_h = hs_log.size();
    while (edge_count < 11) step();
    check("rme_level_pre", level[0], 1'b0);
    step();
    check("rme_level_rise", level[0], 1'b1);
    check("rme_valid_pre", evt_if.evt_valid, 1'b0);
    evt_if.evt_ready = 1'b1;
    step();
    check("rme_evt_valid", evt_if.evt_valid, 1'b1);
    check("rme_evt_idx", evt_if.evt_idx, 2'd0);
    step();
    check("rme_evt_done", evt_if.evt_valid, 1'b0);
    repeat (10) step();
    check("rme_evt_count", hs_log.size() - base_h, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
